// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load sequencer: load op encodings,
// FSM states and the alignment/legality check applied to incoming requests.
package mem_pkg;

   localparam logic [2:0] LOAD_LW  = 3'd0;
   localparam logic [2:0] LOAD_LH  = 3'd1;
   localparam logic [2:0] LOAD_LHU = 3'd2;
   localparam logic [2:0] LOAD_LB  = 3'd3;
   localparam logic [2:0] LOAD_LBU = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Illegal op encodings are folded in so one test rejects every unserviceable request.
   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
      logic bad;
      case (op)
         LOAD_LW:            bad = (addr_lo != 2'b00);
         LOAD_LH, LOAD_LHU:  bad = addr_lo[0];
         LOAD_LB, LOAD_LBU:  bad = 1'b0;
         default:            bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/extender.sv
// Parameterised lane extender: widens a WIDTH-bit value to 32 bits,
// replicating its MSB when sext is set and zero-filling otherwise.
module extender #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  logic             sext,
   output logic [31:0]      result
);

   logic fill_s;

   // Upper bits come from the lane MSB only for signed loads.
   always_comb begin
      fill_s = sext & value[WIDTH-1];
      result = {{(32-WIDTH){fill_s}}, value};
   end

endmodule

// File: rtl/lane_extend.sv
// Picks the addressed byte/halfword out of a little-endian memory word and
// extends it to 32 bits according to the load op.
module lane_extend
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  op,
   output logic [31:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        sext_s;
   logic [31:0] byte_ext_s;
   logic [31:0] half_ext_s;

   // Lane selection and signedness decode.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         2'd3:    byte_s = word[31:24];
         default: byte_s = 8'd0;
      endcase
      if (addr_lo[1]) begin
         half_s = word[31:16];
      end else begin
         half_s = word[15:0];
      end
      sext_s = (op == LOAD_LB) || (op == LOAD_LH);
   end

   extender #(.WIDTH(8)) u_byte_ext (
      .value  (byte_s),
      .sext   (sext_s),
      .result (byte_ext_s)
   );

   extender #(.WIDTH(16)) u_half_ext (
      .value  (half_s),
      .sext   (sext_s),
      .result (half_ext_s)
   );

   // Final result mux by access size.
   always_comb begin
      case (op)
         LOAD_LW:            result = word;
         LOAD_LH, LOAD_LHU:  result = half_ext_s;
         LOAD_LB, LOAD_LBU:  result = byte_ext_s;
         default:            result = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_load_ctrl.sv
// MEM-stage load sequencer: accepts one load, issues a word-aligned read,
// waits (bounded) for the ack, extends the lane and hands it to writeback.
module mem_load_ctrl
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_err
);

   state_e             state_r;
   state_e             next_state_s;
   logic [2:0]         op_r;
   logic [1:0]         addr_lo_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [31:0]        lane_data_s;
   logic               timeout_s;
   logic               resp_load_s;
   logic [31:0]        resp_data_s;
   logic               resp_err_s;

   lane_extend u_lane (
      .word    (mem_rdata),
      .addr_lo (addr_lo_r),
      .op      (op_r),
      .result  (lane_data_s)
   );

   // Next-state decode plus the response payload captured on entry to RESP.
   always_comb begin
      next_state_s = state_r;
      resp_load_s  = 1'b0;
      resp_data_s  = 32'd0;
      resp_err_s   = 1'b0;
      timeout_s    = (cnt_r == CNT_W'(TIMEOUT - 1));
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               if (is_misaligned(req_op, req_addr[1:0])) begin
                  next_state_s = ST_RESP;
                  resp_load_s  = 1'b1;
                  resp_err_s   = 1'b1;
               end else begin
                  next_state_s = ST_ISSUE;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (mem_ack) begin
               next_state_s = ST_RESP;
               resp_load_s  = 1'b1;
               resp_data_s  = lane_data_s;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // An ack in the final wait cycle still wins over the timeout.
            if (mem_ack) begin
               next_state_s = ST_RESP;
               resp_load_s  = 1'b1;
               resp_data_s  = lane_data_s;
            end else if (timeout_s) begin
               next_state_s = ST_RESP;
               resp_load_s  = 1'b1;
               resp_err_s   = 1'b1;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RESP;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         op_r       <= LOAD_LW;
         addr_lo_r  <= 2'b00;
         cnt_r      <= {CNT_W{1'b0}};
         req_ready  <= 1'b1;
         mem_req    <= 1'b0;
         mem_addr   <= 32'd0;
         resp_valid <= 1'b0;
         resp_data  <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         req_ready <= (next_state_s == ST_IDLE);
         mem_req   <= (next_state_s == ST_ISSUE);
         if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= {CNT_W{1'b0}};
         end
         if ((state_r == ST_IDLE) && req_valid) begin
            op_r      <= req_op;
            addr_lo_r <= req_addr[1:0];
            mem_addr  <= {req_addr[31:2], 2'b00};
         end
         if (resp_load_s) begin
            resp_valid <= 1'b1;
            resp_data  <= resp_data_s;
            resp_err   <= resp_err_s;
         end else if ((state_r == ST_RESP) && resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Self-checking bench for mem_load_ctrl: directed vector table, hand-written
// reset corner case and randomized loads checked against a behavioural model.
module tb_mem_load_ctrl;

   localparam int TIMEOUT = 16;
   localparam int NO_ACK  = 999;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_load_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] rdata;
      int          delay;
      int          hold;
      int          late_ack;
      bit          spur;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   // Reference model: which requests are rejected without a memory access.
   function automatic bit ref_bad(input logic [2:0] op, input logic [31:0] addr);
      int a;
      a = int'(addr % 32'd4);
      if (op > 3'd4) return 1'b1;
      if (op == 3'd0 && a != 0) return 1'b1;
      if ((op == 3'd1 || op == 3'd2) && (a % 2) != 0) return 1'b1;
      return 1'b0;
   endfunction

   // Reference model: loaded value computed with shifts, masks and arithmetic.
   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] w);
      logic [31:0] v;
      int          a;
      a = int'(addr % 32'd4);
      case (op)
         3'd0: v = w;
         3'd1, 3'd2: begin
            v = (w >> (8 * a)) & 32'h0000_FFFF;
            if (op == 3'd1 && v >= 32'h0000_8000) v = v - 32'h0001_0000;
         end
         3'd3, 3'd4: begin
            v = (w >> (8 * a)) & 32'h0000_00FF;
            if (op == 3'd3 && v >= 32'h0000_0080) v = v - 32'h0000_0100;
         end
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, ".req_ready"},  {31'd0, req_ready},  32'd1);
      chk({tag, ".mem_req"},    {31'd0, mem_req},    32'd0);
      chk({tag, ".mem_addr"},   mem_addr,            32'd0);
      chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, ".resp_data"},  resp_data,           32'd0);
      chk({tag, ".resp_err"},   {31'd0, resp_err},   32'd0);
   endtask

   // One full transaction from IDLE back to IDLE, cycle-accurate against the latency rules.
   task automatic run_txn(input vec_t v, input string tag);
      bit badreq;
      int lat;
      badreq = ref_bad(v.op, v.addr);
      if (badreq) lat = 1;
      else if (v.delay <= TIMEOUT) lat = 2 + v.delay;
      else lat = 2 + TIMEOUT;
      chk({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = v.op;
      req_addr  = v.addr;
      for (int k = 1; k <= lat + v.hold; k++) begin
         step();
         req_valid  = v.spur && (k >= lat);
         req_op     = 3'd0;
         req_addr   = $urandom;
         mem_ack    = (k == 1 + v.delay) || (k == v.late_ack);
         mem_rdata  = (k == 1 + v.delay) ? v.rdata : $urandom;
         resp_ready = (k == lat + v.hold);
         chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, (!badreq && k == 1)});
         if (!badreq && k == 1) chk({tag, ".mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
         chk({tag, ".resp_valid"}, {31'd0, resp_valid}, {31'd0, (k >= lat)});
         chk({tag, ".busy_ready"}, {31'd0, req_ready}, 32'd0);
         if (k >= lat) begin
            chk({tag, ".resp_data"}, resp_data, v.exp_data);
            chk({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
         end
      end
      step();
      req_valid  = 1'b0;
      mem_ack    = 1'b0;
      resp_ready = 1'b0;
      chk({tag, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, ".done_err"},   {31'd0, resp_err},   32'd0);
      chk({tag, ".done_ready"}, {31'd0, req_ready},  32'd1);
      if (v.spur) begin
         step();
         chk({tag, ".spur_no_req"},   {31'd0, mem_req},    32'd0);
         chk({tag, ".spur_no_valid"}, {31'd0, resp_valid}, 32'd0);
         chk({tag, ".spur_ready"},    {31'd0, req_ready},  32'd1);
      end
   endtask

   vec_t vecs[11];
   vec_t rv;

   initial begin
      // op, addr, rdata, delay, hold, late_ack, spur, exp_data, exp_err
      vecs[0]  = '{3'd3, 32'h0000_1003, 32'h80FF_1234, 1, 0, 0, 1'b0, 32'hFFFF_FF80, 1'b0};
      vecs[1]  = '{3'd2, 32'h0000_0002, 32'h9ABC_0000, 0, 0, 0, 1'b0, 32'h0000_9ABC, 1'b0};
      vecs[2]  = '{3'd0, 32'h0000_0006, 32'h1111_1111, 0, 0, 0, 1'b0, 32'h0000_0000, 1'b1};
      vecs[3]  = '{3'd1, 32'h0000_0001, 32'h2222_2222, 0, 0, 0, 1'b0, 32'h0000_0000, 1'b1};
      vecs[4]  = '{3'd0, 32'h0000_0010, 32'h3333_3333, NO_ACK, 4, 2 + TIMEOUT + 3, 1'b0,
                   32'h0000_0000, 1'b1};
      vecs[5]  = '{3'd0, 32'h0000_0020, 32'hDEAD_BEEF, 2, 5, 0, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[6]  = '{3'd0, 32'h0000_0040, 32'h1234_5678, TIMEOUT, 0, 0, 1'b0, 32'h1234_5678, 1'b0};
      vecs[7]  = '{3'd1, 32'h0000_0002, 32'h8001_0000, 0, 1, 0, 1'b0, 32'hFFFF_8001, 1'b0};
      vecs[8]  = '{3'd4, 32'h0000_0001, 32'h0000_AB00, 3, 0, 0, 1'b0, 32'h0000_00AB, 1'b0};
      vecs[9]  = '{3'd5, 32'h0000_0000, 32'h4444_4444, 0, 2, 0, 1'b0, 32'h0000_0000, 1'b1};
      vecs[10] = '{3'd3, 32'h0000_0000, 32'h0000_007F, 1, 0, 0, 1'b0, 32'h0000_007F, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0; resp_ready = 1'b0;
      step();
      step();
      chk_reset_values("reset");
      rst = 1'b0;
      step();

      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while waiting for memory: the pending ack must be dropped.
      req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0050;
      step();
      req_valid = 1'b0;
      chk("rstwait.mem_req", {31'd0, mem_req}, 32'd1);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_values("rstwait");
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      chk_reset_values("rstack");
      run_txn('{3'd4, 32'h0000_0003, 32'hF000_0000, 1, 0, 0, 1'b0, 32'h0000_00F0, 1'b0}, "after_rst");

      // Randomized loads checked against the reference model.
      for (int n = 0; n < 40; n++) begin
         int r;
         rv.op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
         rv.addr  = $urandom;
         rv.rdata = $urandom;
         r = $urandom_range(0, 9);
         if (r == 0) rv.delay = NO_ACK;
         else if (r == 1) rv.delay = TIMEOUT;
         else rv.delay = $urandom_range(0, 4);
         rv.hold     = $urandom_range(0, 2);
         rv.late_ack = 0;
         rv.spur     = ($urandom_range(0, 3) == 0);
         if (ref_bad(rv.op, rv.addr) || rv.delay > TIMEOUT) begin
            rv.exp_data = 32'd0;
            rv.exp_err  = 1'b1;
         end else begin
            rv.exp_data = ref_load(rv.op, rv.addr, rv.rdata);
            rv.exp_err  = 1'b0;
         end
         run_txn(rv, $sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
